load_store_unit: RTL and testbench

Load/store front end placed directly upstream of the word-addressed data memory (`DataMem`). It accepts one RV32I load/store request at a time from the execute stage over a valid/ready handshake. It converts byte addresses to word indices, performs byte/halfword extraction with sign/zero extension on loads, and implements sub-word stores as read-modify-write, since `DataMem` writes whole words only. It also flags misaligned, out-of-range and illegal-width accesses without touching memory.

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_lane.sv | 53 +++++
 rtl/load_store_unit.sv | 170 +++++++++++++++++
 tb/tb_load_store_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 width codes and FSM state encoding.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [2:0] {
    StIdle,
    StLdRd,
    StLdWait,
    StStWr,
    StRmwRd,
    StRmwWait,
    StRmwWr,
    StErr
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane.sv
// Byte/halfword lane steering: load extraction with extension, and sub-word store merge.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] mem_word_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] ld_value_o,
  output logic [31:0] st_merged_o
);

  logic [31:0] shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    shifted = mem_word_i >> {addr_lo_i, 3'b000};
    ld_byte = shifted[7:0];
    ld_half = addr_lo_i[1] ? mem_word_i[31:16] : mem_word_i[15:0];
  end

  always_comb begin
    ld_value_o = '0;
    unique case (funct3_i)
      LB:      ld_value_o = {{24{ld_byte[7]}}, ld_byte};
      LH:      ld_value_o = {{16{ld_half[15]}}, ld_half};
      LW:      ld_value_o = mem_word_i;
      LBU:     ld_value_o = {24'b0, ld_byte};
      LHU:     ld_value_o = {16'b0, ld_half};
      default: ld_value_o = '0;
    endcase
  end

  // Untouched lanes keep the word just read from memory.
  always_comb begin
    st_merged_o = mem_word_i;
    unique case (funct3_i)
      SB: begin
        for (int i = 0; i < 4; i++) begin
          if (addr_lo_i == 2'(i)) st_merged_o[8*i +: 8] = st_data_i[7:0];
        end
      end
      SH: begin
        if (addr_lo_i[1]) st_merged_o[31:16] = st_data_i[15:0];
        else              st_merged_o[15:0]  = st_data_i[15:0];
      end
      SW:      st_merged_o = st_data_i;
      default: st_merged_o = mem_word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store front end for a word-only DataMem: request FSM, error check,
// sub-word stores via read-modify-write. All outputs are registered.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned WORDS = 1024
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Req_Valid,
  output logic        o_Req_Ready,
  input  logic        i_Req_We,
  input  logic [2:0]  i_Req_Funct3,
  input  logic [31:0] i_Req_Addr,
  input  logic [31:0] i_Req_WData,
  output logic        o_Rsp_Valid,
  output logic        o_Rsp_Err,
  output logic [31:0] o_Rsp_RData,
  output logic        o_Mem_WriteEn,
  output logic [31:0] o_Mem_Write_Addr,
  output logic [31:0] o_Mem_Write_Data,
  output logic        o_Mem_ReadEn,
  output logic [31:0] o_Mem_Read_Addr,
  input  logic [31:0] i_Mem_Read_Data
);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_waddr_q, mem_waddr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_re_q, mem_re_d;
  logic [31:0] mem_raddr_q, mem_raddr_d;

  logic        accept;
  logic        req_err;
  logic        bad_funct3;
  logic        misaligned;
  logic        out_of_range;
  logic [31:0] cur_addr;
  logic [31:0] word_idx;
  logic [31:0] ld_value;
  logic [31:0] st_merged;

  lsu_lane u_lane (
    .funct3_i    (funct3_q),
    .addr_lo_i   (addr_q[1:0]),
    .mem_word_i  (i_Mem_Read_Data),
    .st_data_i   (wdata_q),
    .ld_value_o  (ld_value),
    .st_merged_o (st_merged)
  );

  assign accept = i_Req_Valid & ready_q;

  // Errors are judged on the live request, since they are decided in the accept cycle.
  always_comb begin
    bad_funct3 = 1'b1;
    unique case (i_Req_Funct3)
      LB, LH, LW: bad_funct3 = 1'b0;
      LBU, LHU:   bad_funct3 = i_Req_We;
      default:    bad_funct3 = 1'b1;
    endcase
    misaligned = ((i_Req_Funct3[1:0] == 2'b01) && i_Req_Addr[0]) ||
                 ((i_Req_Funct3[1:0] == 2'b10) && (i_Req_Addr[1:0] != 2'b00));
    out_of_range = {2'b00, i_Req_Addr[31:2]} >= 32'(WORDS);
    req_err = bad_funct3 | misaligned | out_of_range;
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          we_d     = i_Req_We;
          funct3_d = i_Req_Funct3;
          addr_d   = i_Req_Addr;
          wdata_d  = i_Req_WData;
          if (req_err)                   state_d = StErr;
          else if (!i_Req_We)            state_d = StLdRd;
          else if (i_Req_Funct3 == SW)   state_d = StStWr;
          else                           state_d = StRmwRd;
        end
      end
      StLdRd:    state_d = StLdWait;
      StLdWait:  state_d = StIdle;
      StStWr:    state_d = StIdle;
      StRmwRd:   state_d = StRmwWait;
      StRmwWait: state_d = StRmwWr;
      StRmwWr:   state_d = StIdle;
      StErr:     state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state, so first-cycle values use the live request.
  always_comb begin
    cur_addr    = (state_q == StIdle) ? i_Req_Addr : addr_q;
    word_idx    = {2'b00, cur_addr[31:2]};
    ready_d     = (state_d == StIdle);
    mem_we_d    = (state_d == StStWr) || (state_d == StRmwWr);
    mem_re_d    = (state_d == StLdRd) || (state_d == StRmwRd);
    mem_waddr_d = mem_we_d ? word_idx : '0;
    mem_raddr_d = mem_re_d ? word_idx : '0;
    mem_wdata_d = '0;
    if (state_d == StStWr)       mem_wdata_d = i_Req_WData;
    else if (state_d == StRmwWr) mem_wdata_d = st_merged;
    rsp_valid_d = (state_q == StLdWait) || (state_d == StStWr) ||
                  (state_d == StRmwWr) || (state_d == StErr);
    rsp_err_d   = (state_d == StErr);
    rsp_rdata_d = (state_q == StLdWait) ? ld_value : '0;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      mem_re_q    <= 1'b0;
      mem_raddr_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_re_q    <= mem_re_d;
      mem_raddr_q <= mem_raddr_d;
    end
  end

  assign o_Req_Ready      = ready_q;
  assign o_Rsp_Valid      = rsp_valid_q;
  assign o_Rsp_Err        = rsp_err_q;
  assign o_Rsp_RData      = rsp_rdata_q;
  assign o_Mem_WriteEn    = mem_we_q;
  assign o_Mem_Write_Addr = mem_waddr_q;
  assign o_Mem_Write_Data = mem_wdata_q;
  assign o_Mem_ReadEn     = mem_re_q;
  assign o_Mem_Read_Addr  = mem_raddr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-addressed DataMem model.
module tb_load_store_unit;

  localparam int unsigned Words = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_re;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata = '0;

  logic [31:0] mem [Words];

  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;
  int n_rsp = 0;
  logic [31:0] rsp_log[$];

  logic [31:0] s_re[5], s_we[5], s_waddr[5], s_wdata[5], s_raddr[5];
  logic [31:0] s_vld[5], s_err[5], s_rdata[5], s_rdy[5];

  always #5 clk = ~clk;

  load_store_unit #(.WORDS(Words)) u_dut (
    .i_Clk            (clk),
    .i_Rst_n          (rst_n),
    .i_Req_Valid      (req_valid),
    .o_Req_Ready      (req_ready),
    .i_Req_We         (req_we),
    .i_Req_Funct3     (req_funct3),
    .i_Req_Addr       (req_addr),
    .i_Req_WData      (req_wdata),
    .o_Rsp_Valid      (rsp_valid),
    .o_Rsp_Err        (rsp_err),
    .o_Rsp_RData      (rsp_rdata),
    .o_Mem_WriteEn    (mem_we),
    .o_Mem_Write_Addr (mem_waddr),
    .o_Mem_Write_Data (mem_wdata),
    .o_Mem_ReadEn     (mem_re),
    .o_Mem_Read_Addr  (mem_raddr),
    .i_Mem_Read_Data  (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr[9:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_raddr[9:0]];
  end

  always @(negedge clk) begin
    if (mem_we) n_writes++;
    if (rsp_valid) begin
      n_rsp++;
      rsp_log.push_back(rsp_rdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sample(input int c);
    s_re[c]    = 32'(mem_re);
    s_we[c]    = 32'(mem_we);
    s_waddr[c] = mem_waddr;
    s_wdata[c] = mem_wdata;
    s_raddr[c] = mem_raddr;
    s_vld[c]   = 32'(rsp_valid);
    s_err[c]   = 32'(rsp_err);
    s_rdata[c] = rsp_rdata;
    s_rdy[c]   = 32'(req_ready);
  endtask

  // Issue one request and record outputs in T1..T4 relative to the accept cycle T0.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd);
    int w;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    sample(1);
    for (int c = 2; c <= 4; c++) begin
      @(posedge clk);
      #1 sample(c);
    end
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] exp);
    xact(1'b0, f3, addr, 32'h0);
    check({tag, "_re_t1"}, s_re[1], 32'd1);
    check({tag, "_raddr_t1"}, s_raddr[1], {2'b00, addr[31:2]});
    check({tag, "_vld_t3"}, s_vld[3], 32'd1);
    check({tag, "_rdata_t3"}, s_rdata[3], exp);
    check({tag, "_err_t3"}, s_err[3], 32'd0);
  endtask

  task automatic do_error(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr);
    xact(we, f3, addr, 32'hFFFF_FFFF);
    check({tag, "_vld_t1"}, s_vld[1], 32'd1);
    check({tag, "_err_t1"}, s_err[1], 32'd1);
    check({tag, "_rdata_t1"}, s_rdata[1], 32'd0);
    check({tag, "_en_t1"}, s_re[1] | s_we[1], 32'd0);
    check({tag, "_en_t2"}, s_re[2] | s_we[2], 32'd0);
    check({tag, "_rdy_t2"}, s_rdy[2], 32'd1);
  endtask

  logic        b_we[6];
  logic [2:0]  b_f3[6];
  logic [31:0] b_addr[6];
  logic [31:0] b_wd[6];
  logic [31:0] b_exp[6];

  initial begin
    int k;
    int cyc;
    int w0;
    int r0;
    logic rdy;
    for (int i = 0; i < int'(Words); i++) mem[i] = '0;

    // Reset state
    #12;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_outs", 32'(rsp_valid | rsp_err | mem_we | mem_re), 32'd0);
    check("rst_data", rsp_rdata | mem_waddr | mem_wdata | mem_raddr, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // SW then LW
    xact(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    check("sw_we_t1", s_we[1], 32'd1);
    check("sw_waddr_t1", s_waddr[1], 32'd4);
    check("sw_wdata_t1", s_wdata[1], 32'hDEAD_BEEF);
    check("sw_vld_t1", s_vld[1], 32'd1);
    check("sw_rdy_t1", s_rdy[1], 32'd0);
    check("sw_rdy_t2", s_rdy[2], 32'd1);
    check("sw_we_t2", s_we[2], 32'd0);
    do_load("lw", 3'b010, 32'h10, 32'hDEAD_BEEF);
    check("lw_vld_t2", s_vld[2], 32'd0);
    check("lw_re_t2", s_re[2], 32'd0);
    check("lw_rdy_t3", s_rdy[3], 32'd1);

    // Sub-word loads
    do_load("lb", 3'b000, 32'h13, 32'hFFFF_FFDE);
    do_load("lbu", 3'b100, 32'h13, 32'h0000_00DE);
    do_load("lh", 3'b001, 32'h12, 32'hFFFF_DEAD);
    do_load("lhu", 3'b101, 32'h10, 32'h0000_BEEF);
    do_load("lb0", 3'b000, 32'h10, 32'hFFFF_FFEF);

    // Sub-word stores
    xact(1'b1, 3'b000, 32'h11, 32'h0000_0055);
    check("sb_re_t1", s_re[1], 32'd1);
    check("sb_we_t1", s_we[1], 32'd0);
    check("sb_we_t2", s_we[2], 32'd0);
    check("sb_we_t3", s_we[3], 32'd1);
    check("sb_waddr_t3", s_waddr[3], 32'd4);
    check("sb_wdata_t3", s_wdata[3], 32'hDEAD_55EF);
    check("sb_vld_t3", s_vld[3], 32'd1);
    check("sb_rdy_t4", s_rdy[4], 32'd1);
    xact(1'b1, 3'b001, 32'h12, 32'hABCD_1234);
    check("sh_wdata_t3", s_wdata[3], 32'h1234_55EF);
    check("sh_vld_t3", s_vld[3], 32'd1);
    do_load("lw_after_sh", 3'b010, 32'h10, 32'h1234_55EF);

    // Rejected accesses
    do_error("err_lw_mis", 1'b0, 3'b010, 32'h02);
    do_error("err_sh_mis", 1'b1, 3'b001, 32'h01);
    do_error("err_f3_011", 1'b0, 3'b011, 32'h10);
    do_error("err_range", 1'b0, 3'b010, 32'(4 * Words));
    do_error("err_st_lbu", 1'b1, 3'b100, 32'h10);

    // Last legal word
    xact(1'b1, 3'b010, 32'hFFC, 32'hA5A5_0001);
    check("top_sw_err", s_err[1], 32'd0);
    check("top_sw_waddr", s_waddr[1], 32'd1023);
    do_load("top_lw", 3'b010, 32'hFFC, 32'hA5A5_0001);

    // Reset during RMW_WAIT of an SB
    w0 = n_writes;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h10;
    req_wdata  = 32'h0000_00AA;
    check("rmw_rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rmw_rst_outs", 32'(rsp_valid | rsp_err | mem_we | mem_re | req_ready), 32'd0);
    check("rmw_rst_data", rsp_rdata | mem_waddr | mem_wdata | mem_raddr, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    check("rmw_rst_nowrite", 32'(n_writes - w0), 32'd0);
    check("rmw_rst_mem", mem[4], 32'h1234_55EF);
    do_load("rmw_rst_lw", 3'b010, 32'h10, 32'h1234_55EF);

    // Continuous valid, alternating stores and loads
    b_we[0] = 1'b1; b_f3[0] = 3'b010; b_addr[0] = 32'h20; b_wd[0] = 32'h1111_1111; b_exp[0] = '0;
    b_we[1] = 1'b0; b_f3[1] = 3'b010; b_addr[1] = 32'h20; b_wd[1] = '0; b_exp[1] = 32'h1111_1111;
    b_we[2] = 1'b1; b_f3[2] = 3'b000; b_addr[2] = 32'h21; b_wd[2] = 32'h99; b_exp[2] = '0;
    b_we[3] = 1'b0; b_f3[3] = 3'b010; b_addr[3] = 32'h20; b_wd[3] = '0; b_exp[3] = 32'h1111_9911;
    b_we[4] = 1'b1; b_f3[4] = 3'b010; b_addr[4] = 32'h28; b_wd[4] = 32'hCAFE_F00D; b_exp[4] = '0;
    b_we[5] = 1'b0; b_f3[5] = 3'b010; b_addr[5] = 32'h28; b_wd[5] = '0; b_exp[5] = 32'hCAFE_F00D;
    rsp_log.delete();
    r0  = n_rsp;
    k   = 0;
    cyc = 0;
    while (k < 6 && cyc < 100) begin
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = b_we[k];
      req_funct3 = b_f3[k];
      req_addr   = b_addr[k];
      req_wdata  = b_wd[k];
      rdy        = req_ready;
      @(posedge clk);
      if (rdy) k++;
      cyc++;
    end
    @(negedge clk) req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("b2b_accepted", 32'(k), 32'd6);
    check("b2b_rsp_count", 32'(n_rsp - r0), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < rsp_log.size()) check($sformatf("b2b_rdata_%0d", i), rsp_log[i], b_exp[i]);
      else check($sformatf("b2b_missing_%0d", i), 32'(rsp_log.size()), 32'd6);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
